boid_frame_writer: RTL and testbench
====================================

Name: boid_frame_writer

Overview:
- Writer side of the boid pixel framebuffer. The VGA display path only reads this RAM (address x + 640*y, palette-index data).
- Once per frame, triggered by the rising edge of screenEnd, the block erases every boid pixel it drew last frame and plots each boid's current position.
- Drives the framebuffer RAM write port (addr/dataIn/wEn) and reads the boid position table through an index/data interface.

Parameters:
NUM_BOIDS, 16, number of boids drawn per frame (table depth)
WIDTH, 640, visible pixels per line
HEIGHT, 480, visible lines
ADDR_WIDTH, 20, framebuffer address width
DATA_WIDTH, 9, palette index width
BOID_COLOR, 42, palette index written for a boid pixel
BG_COLOR, 31, palette index written when erasing

Ports:
clk  input  1  100 MHz system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
screenEnd  input  1  frame-boundary level from the timing generator; rising edge starts a pass
boid_idx  output  $clog2(NUM_BOIDS)  index into boid position table
boid_x  input  10  x of boid[boid_idx], combinational, valid same cycle
boid_y  input  9  y of boid[boid_idx], combinational, valid same cycle
wr_addr  output  ADDR_WIDTH  framebuffer write address
wr_data  output  DATA_WIDTH  framebuffer write data
wr_en  output  1  framebuffer write enable, one write per cycle high
busy  output  1  high while a pass is in progress
frame_done  output  1  one-cycle pulse when a pass completes
overrun  output  1  one-cycle pulse when a screenEnd edge arrives while busy

Behaviour:
- Reset (reset=0, async):
  - State IDLE; boid_idx, wr_addr, wr_data, wr_en, busy, frame_done, overrun all 0.
  - screenEnd edge register cleared to 0.
  - All NUM_BOIDS old-position valid bits cleared.
- Edge detect: se_q <= screenEnd each cycle. start = screenEnd & ~se_q. screenEnd stays high about 4 clk cycles; exactly one start per frame.
- FSM states:
  - IDLE: start -> ERASE, idx counter = 0, busy = 1 next cycle.
  - ERASE: one cycle per entry i = 0..NUM_BOIDS-1.
    - If old_valid[i]: register wr_en=1, wr_addr=old_addr[i], wr_data=BG_COLOR.
    - Else wr_en=0.
    - After i = NUM_BOIDS-1 -> DRAW, idx = 0.
  - DRAW: one cycle per entry i.
    - boid_idx = i; sample boid_x/boid_y the same cycle.
    - In bounds (boid_x < WIDTH and boid_y < HEIGHT): register wr_en=1, wr_addr = boid_x + WIDTH*boid_y (full-width arithmetic, no truncation before ADDR_WIDTH), wr_data=BOID_COLOR; old_addr[i] <= that address; old_valid[i] <= 1.
    - Out of bounds: wr_en=0, old_valid[i] <= 0.
    - After i = NUM_BOIDS-1 -> DONE.
  - DONE: one cycle. frame_done=1, busy=0 on exit, wr_en=0 -> IDLE.
- Latency: wr_* outputs are registered, so the write for step i appears the cycle after step i is processed. The first erase write appears 2 cycles after the cycle where screenEnd first reads high. A full pass is 2*NUM_BOIDS + 2 cycles from start to frame_done (34 for defaults).
- Ordering: all erases precede all draws. A pixel both erased and redrawn in the same pass ends as BOID_COLOR. Duplicate boid positions produce duplicate writes (harmless).
- start while busy (ERASE/DRAW/DONE): ignored, overrun pulses 1 cycle, and the pass continues unchanged.
- wr_en is 0 in IDLE. wr_addr/wr_data hold their last value when wr_en=0.
- boid_idx holds its last value outside DRAW.
- Reset mid-pass aborts immediately. No erase writes occur on the next pass (valid bits cleared), so stale pixels remain until overwritten; this is accepted.

Test Plan:
- Reset release, screenEnd low for 100 cycles -> wr_en, busy, frame_done, overrun stay 0; boid_idx=0.
- Boid k at (10k,10k) for k=0..15, one screenEnd pulse -> no erase writes; 16 writes with addr = 6410k, data 42, in index order; frame_done 34 cycles after start.
- Second pulse with positions moved to (10k+1,10k+1) -> 16 writes addr 6410k, data 31, then 16 writes addr 6410k+641, data 42.
- Boid 3 at x=640 (y=5) -> no write for index 3 in DRAW; next pass has no erase write for index 3; other 15 boids unaffected.
- Second screenEnd rising edge injected 10 cycles into a pass -> overrun pulses once; write sequence identical to the undisturbed case; exactly one frame_done.
- reset asserted mid-DRAW at index 7 -> all outputs 0 asynchronously; after release, next pass issues zero erase writes and 16 draw writes.

Source files
------------

// File: rtl/boid_frame_writer_if.sv
// boid_frame_writer_if: framebuffer write port plus boid position table lookup.
interface boid_frame_writer_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 9,
    parameter int IDX_W      = 4
);
    logic [IDX_W-1:0]      boid_idx;
    logic [9:0]            boid_x;
    logic [8:0]            boid_y;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    modport master (output boid_idx, wr_addr, wr_data, wr_en, input boid_x, boid_y);
    modport slave  (input boid_idx, wr_addr, wr_data, wr_en, output boid_x, boid_y);
endinterface

// File: rtl/boid_frame_writer.sv
// boid_frame_writer: per frame, erase last frame's boid pixels then plot current positions.
module boid_frame_writer #(
    parameter int NUM_BOIDS  = 16,
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 9,
    parameter int BOID_COLOR = 42,
    parameter int BG_COLOR   = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 screenEnd,
    boid_frame_writer_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun
);
    localparam int IDX_W = $clog2(NUM_BOIDS);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
    state_t state, nxt;
    logic se_q, start, last, in_b;
    logic [IDX_W-1:0] idx, last_idx;
    logic [NUM_BOIDS-1:0] old_valid;
    logic [ADDR_WIDTH-1:0] old_addr [NUM_BOIDS];
    logic [ADDR_WIDTH-1:0] pix;

    assign start = screenEnd & ~se_q;
    assign last  = idx == IDX_W'(NUM_BOIDS - 1);
    assign in_b  = 32'(bus.boid_x) < WIDTH && 32'(bus.boid_y) < HEIGHT;
    assign pix   = ADDR_WIDTH'(bus.boid_x) + ADDR_WIDTH'(WIDTH) * ADDR_WIDTH'(bus.boid_y);
    // table index follows the counter only while drawing, otherwise holds
    assign bus.boid_idx = state == DRAW ? idx : last_idx;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? ERASE : IDLE;
            ERASE:   nxt = last ? DRAW : ERASE;
            DRAW:    nxt = last ? DONE : DRAW;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            se_q        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            idx         <= '0;
            last_idx    <= '0;
            old_valid   <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            se_q       <= screenEnd;
            busy       <= nxt != IDLE;
            frame_done <= state == DONE;
            overrun    <= start && state != IDLE;
            idx        <= (state == ERASE || state == DRAW) && !last ? idx + IDX_W'(1) : '0;
            bus.wr_en  <= state == ERASE ? old_valid[idx] : state == DRAW && in_b;
            if (state == ERASE && old_valid[idx]) begin
                bus.wr_addr <= old_addr[idx];
                bus.wr_data <= DATA_WIDTH'(BG_COLOR);
            end
            if (state == DRAW) begin
                last_idx       <= idx;
                old_valid[idx] <= in_b;
                if (in_b) begin
                    bus.wr_addr <= pix;
                    bus.wr_data <= DATA_WIDTH'(BOID_COLOR);
                end
            end
        end

    // contents are only meaningful where old_valid is set, so no reset needed
    always_ff @(posedge clk)
        if (state == DRAW && in_b) old_addr[idx] <= pix;
endmodule

// File: tb/tb_boid_frame_writer.sv
// tb_boid_frame_writer: directed and random frame passes checked against a write-list model.
module tb_boid_frame_writer;
    localparam int NB = 16;
    logic clk = 1'b0, reset = 1'b0, screenEnd = 1'b0;
    logic busy, frame_done, overrun;
    logic [9:0] bx [NB];
    logic [8:0] by [NB];
    int total = 0, bad = 0, cyc = 0, fd_cnt = 0, ov_cnt = 0, fd_cyc = -1;
    int wq[$];
    int old_a [NB];

    boid_frame_writer_if #(.ADDR_WIDTH(20), .DATA_WIDTH(9), .IDX_W(4)) bus ();
    boid_frame_writer dut (.clk(clk), .reset(reset), .screenEnd(screenEnd), .bus(bus.master),
                           .busy(busy), .frame_done(frame_done), .overrun(overrun));

    always #5 clk = ~clk;
    assign bus.boid_x = bx[bus.boid_idx];
    assign bus.boid_y = by[bus.boid_idx];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.wr_en) wq.push_back(int'({bus.wr_addr, bus.wr_data}));
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (overrun) ov_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected writes: every remembered pixel in BG, then every in-bounds boid in BOID colour
    task automatic run_pass(input int ovr, input string tag);
        int exp_q[$];
        int t0, n;
        for (int k = 0; k < NB; k++)
            if (old_a[k] >= 0) exp_q.push_back(old_a[k] * 512 + 31);
        for (int k = 0; k < NB; k++)
            if (int'(bx[k]) < 640 && int'(by[k]) < 480) begin
                old_a[k] = int'(bx[k]) + 640 * int'(by[k]);
                exp_q.push_back(old_a[k] * 512 + 42);
            end else old_a[k] = -1;
        wq.delete();
        fd_cnt = 0; ov_cnt = 0; fd_cyc = -1;
        @(negedge clk); screenEnd = 1'b1; t0 = cyc;
        repeat (4) @(negedge clk);
        chk({tag, " busy_mid"}, int'(busy), 1);
        screenEnd = 1'b0;
        if (ovr != 0) begin
            repeat (6) @(negedge clk);
            screenEnd = 1'b1;
            repeat (2) @(negedge clk);
            screenEnd = 1'b0;
        end
        n = 0;
        while (fd_cnt == 0 && n < 200) begin @(negedge clk); #1; n++; end
        chk({tag, " fd_latency"}, fd_cyc - t0, 34);
        repeat (5) @(negedge clk);
        #1;
        chk({tag, " fd_count"}, fd_cnt, 1);
        chk({tag, " overrun_count"}, ov_cnt, ovr);
        chk({tag, " busy_end"}, int'(busy), 0);
        chk({tag, " n_writes"}, wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, " write"}, i < wq.size() ? wq[i] : -1, exp_q[i]);
    endtask

    initial begin
        int n;
        for (int k = 0; k < NB; k++) begin old_a[k] = -1; bx[k] = '0; by[k] = '0; end
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({bus.wr_en, busy, frame_done, overrun, bus.boid_idx}), 0);
        chk("reset_addr_data", int'({bus.wr_addr, bus.wr_data}), 0);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle", int'({bus.wr_en, busy, frame_done, overrun, bus.boid_idx}), 0);
        end

        for (int k = 0; k < NB; k++) begin bx[k] = 10'(10 * k); by[k] = 9'(10 * k); end
        run_pass(0, "first");
        for (int k = 0; k < NB; k++) begin bx[k] = 10'(10 * k + 1); by[k] = 9'(10 * k + 1); end
        run_pass(0, "moved");

        bx[3] = 10'd640; by[3] = 9'd5;
        run_pass(0, "oob");
        for (int k = 0; k < NB; k++) if (k != 3) begin bx[k] = 10'(10 * k + 2); by[k] = 9'(10 * k + 3); end
        run_pass(0, "after_oob");

        run_pass(1, "overrun");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) begin
                bx[k] = 10'($urandom_range(0, 700));
                by[k] = 9'($urandom_range(0, 511));
            end
            run_pass(0, "random");
        end

        @(negedge clk); screenEnd = 1'b1;
        n = 0;
        while (bus.boid_idx != 4'd7 && n < 100) begin
            @(negedge clk); n++;
            if (n == 4) screenEnd = 1'b0;
        end
        chk("reach_draw7", int'(n < 100), 1);
        reset = 1'b0; screenEnd = 1'b0;
        #1;
        chk("midreset_outs", int'({bus.wr_en, busy, frame_done, overrun, bus.boid_idx}), 0);
        chk("midreset_addr_data", int'({bus.wr_addr, bus.wr_data}), 0);
        for (int k = 0; k < NB; k++) old_a[k] = -1;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < NB; k++) begin bx[k] = 10'(20 * k); by[k] = 9'(7 * k); end
        run_pass(0, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
